ofifo: RTL and testbench

OFIFO -- requirements
Module: ofifo

---
 rtl/ofifo.sv | 105 ++++++++++
 tb/tb_ofifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ofifo.sv
// Output FIFO between the PE array and the SFU: one independent circular FIFO per
// column, written with per-lane skew and popped a whole row at a time.

module ofifo_lane #(
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [psum_bw-1:0] din,
    input  logic               pop,
    output logic [psum_bw-1:0] head,
    output logic               nonempty,
    output logic               full,
    output logic               drop
);
    localparam int AW = $clog2(depth);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [AW-1:0]      wptr, rptr;
    logic [AW:0]        cnt;
    logic               accept;

    // Fullness is judged before any same-cycle pop, so a pop never rescues a write.
    assign full     = (cnt == DEPTH_C);
    assign nonempty = (cnt != '0);
    assign accept   = wr && !full;
    assign drop     = wr && full;
    assign head     = mem[rptr];

    // Storage is never reset; occupancy lives in the pointers and count.
    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= din;
    end

    // depth is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [psum_bw*col-1:0] in,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_overflow
);
    logic [col-1:0]              nonempty, full, drop;
    logic [col-1:0][psum_bw-1:0] head;
    logic                        pop;

    assign o_valid = &nonempty;
    assign o_full  = |full;
    assign pop     = rd && o_valid;

    for (genvar g = 0; g < col; g++) begin : g_lane
        ofifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .wr       (wr[g]),
            .din      (in[psum_bw*g +: psum_bw]),
            .pop      (pop),
            .head     (head[g]),
            .nonempty (nonempty[g]),
            .full     (full[g]),
            .drop     (drop[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out        <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (pop)   out        <= head;
            if (|drop) o_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ofifo.sv
// Directed bench for ofifo with default parameters (8 lanes x 16 bits, depth 64).

module tb_ofifo;
    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   wr;
    logic [127:0] in;
    logic         rd;
    logic [127:0] out;
    logic         o_valid, o_full, o_overflow;

    int checks   = 0;
    int failures = 0;

    ofifo dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .in         (in),
        .rd         (rd),
        .out        (out),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] row(input logic [15:0] v);
        return {8{v}};
    endfunction

    // Inputs change on the falling edge; outputs are checked there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wrrow(input logic [127:0] d);
        wr = '1; in = d;
        step();
        wr = '0;
    endtask

    task automatic poprow();
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [127:0] exp;
        wr = '0; in = '0; rd = 1'b0; reset = 1'b1;
        step();
        chk("rst_out",   out,        '0);
        chk("rst_valid", o_valid,    0);
        chk("rst_full",  o_full,     0);
        chk("rst_ovf",   o_overflow, 0);
        reset = 1'b0;
        step();

        // Skewed column writes
        exp = '0;
        for (int g = 0; g < 8; g++) begin
            wr = 8'(1 << g);
            in = '0;
            in[16*g +: 16] = 16'h0010 + 16'(g);
            exp[16*g +: 16] = 16'h0010 + 16'(g);
            step();
            chk($sformatf("skew_valid%0d", g), o_valid, (g == 7));
        end
        wr = '0;
        poprow();
        chk("skew_out",   out,     exp);
        chk("skew_valid", o_valid, 0);

        // Underflow: pop on empty leaves out and counts alone
        wrrow(row(16'h1234));
        poprow();
        chk("uf_load", out, row(16'h1234));
        poprow();
        chk("uf_out",   out,     row(16'h1234));
        chk("uf_valid", o_valid, 0);
        wrrow(row(16'h0005));
        poprow();
        chk("uf_next",  out,     row(16'h0005));
        chk("uf_empty", o_valid, 0);

        // Signed data passes through untouched
        exp = row(16'h0001);
        exp[16*3 +: 16] = 16'h8001;
        wrrow(exp);
        poprow();
        chk("signed", out, exp);

        // Fill, overflow, drain
        for (int k = 0; k < 64; k++) wrrow(row(16'(k)));
        chk("fill_full",  o_full,     1);
        chk("fill_ovf0",  o_overflow, 0);
        wrrow(row(16'hFFFF));
        chk("ovf_set",  o_overflow, 1);
        chk("ovf_full", o_full,     1);
        for (int k = 0; k < 64; k++) begin
            poprow();
            chk($sformatf("drain%0d", k), out, row(16'(k)));
        end
        chk("drain_valid", o_valid,    0);
        chk("drain_ovf",   o_overflow, 1);
        chk("drain_full",  o_full,     0);

        // A same-cycle pop does not rescue a write to a full lane
        do_reset();
        chk("rst2_ovf", o_overflow, 0);
        for (int k = 0; k < 64; k++) wrrow(row(16'(k)));
        wr = '1; in = row(16'hAAAA); rd = 1'b1;
        step();
        wr = '0; rd = 1'b0;
        chk("rescue_out",  out,        row(16'h0000));
        chk("rescue_full", o_full,     0);
        chk("rescue_ovf",  o_overflow, 1);
        for (int k = 1; k < 64; k++) poprow();
        chk("rescue_last",  out,     row(16'd63));
        chk("rescue_empty", o_valid, 0);

        // Wrap: stream 100 rows with write+pop each cycle after the first
        do_reset();
        wrrow(row(16'd0));
        for (int k = 1; k < 100; k++) begin
            wr = '1; in = row(16'(k)); rd = 1'b1;
            step();
            chk($sformatf("wrap%0d", k - 1), out, row(16'(k - 1)));
            chk($sformatf("wrap_full%0d", k), o_full, 0);
        end
        wr = '0;
        step();
        rd = 1'b0;
        chk("wrap99",       out,        row(16'd99));
        chk("wrap_empty",   o_valid,    0);
        chk("wrap_noovf",   o_overflow, 0);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 5; k++) wrrow(row(16'(200 + k)));
        chk("mid_valid", o_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_out",   out,     '0);
        chk("async_valid", o_valid, 0);
        wr = '1; in = row(16'hDEAD); rd = 1'b1;
        step();
        wr = '0; rd = 1'b0; reset = 1'b0;
        chk("rst_ignored", o_valid, 0);
        wrrow(row(16'h0777));
        poprow();
        chk("post_rst_row",   out,     row(16'h0777));
        chk("post_rst_empty", o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
